// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the two-requester RAM port arbiter.
package ram_arb_pkg;

  localparam int unsigned DEPTH_DEF  = 8;
  localparam int unsigned ADDR_W_DEF = 3;
  localparam int unsigned RAM_ADDR_W = 8;
  localparam int unsigned DATA_W     = 4;
  localparam int unsigned CNT_W      = 8;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Command presented to the RAM by the granted requester.
  typedef struct packed {
    logic                  we;
    logic [RAM_ADDR_W-1:0] addr;
    logic [DATA_W-1:0]     data;
  } ram_cmd_t;

endpackage

// File: rtl/ram_port_arbiter_if.sv
// Requester-side handshake bundle: two request channels, a shared read response, init status.
interface ram_port_arbiter_if
  import ram_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF
);

  logic [1:0]        req_valid;
  logic [1:0]        req_we;
  logic [ADDR_W-1:0] req_addr0;
  logic [ADDR_W-1:0] req_addr1;
  logic [DATA_W-1:0] req_wdata0;
  logic [DATA_W-1:0] req_wdata1;
  logic [1:0]        req_ready;
  logic [1:0]        rsp_valid;
  logic [DATA_W-1:0] rsp_data;
  logic              init_done;

  modport master (
    output req_valid, req_we, req_addr0, req_addr1, req_wdata0, req_wdata1,
    input  req_ready, rsp_valid, rsp_data, init_done
  );

  modport slave (
    input  req_valid, req_we, req_addr0, req_addr1, req_wdata0, req_wdata1,
    output req_ready, rsp_valid, rsp_data, init_done
  );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: combinational grant plus the favoured-requester pointer.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [1:0] valid,
  output logic [1:0] grant_c
);

  logic rr_ptr;

  // A lone requester always wins; on contention the pointer picks the winner.
  always_comb begin : grant_sel
    grant_c = 2'b00;
    if (en) begin
      case (valid)
        2'b01:   grant_c = 2'b01;
        2'b10:   grant_c = 2'b10;
        2'b11:   grant_c = rr_ptr ? 2'b10 : 2'b01;
        default: grant_c = 2'b00;
      endcase
    end
  end

  // Only a contended grant moves the pointer, handing priority to the loser.
  always_ff @(posedge clk or negedge rst_n) begin : ptr_reg
    if (!rst_n) begin
      rr_ptr <= 1'b0;
    end else if (en && (valid == 2'b11)) begin
      rr_ptr <= ~rr_ptr;
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Arbitrates two requesters onto a RAM write/read port pair after clearing the RAM post-reset.
// Defining RAM_ARB_STATS_EN adds saturating per-requester grant counters grant_cnt0/grant_cnt1.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int unsigned DEPTH  = DEPTH_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  ram_port_arbiter_if.slave     bus,
  output logic                  ram_write_en,
  output logic [RAM_ADDR_W-1:0] ram_write_addr,
  output logic [DATA_W-1:0]     ram_write_data,
  output logic                  ram_read_en,
  output logic [RAM_ADDR_W-1:0] ram_read_addr,
  input  logic [DATA_W-1:0]     ram_read_data
`ifdef RAM_ARB_STATS_EN
  ,
  output logic [CNT_W-1:0]      grant_cnt0,
  output logic [CNT_W-1:0]      grant_cnt1
`endif
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_e            state, state_nxt;
  logic [ADDR_W-1:0] sweep_addr, sweep_nxt;
  logic              init_done_q, init_done_nxt;
  logic [1:0]        rsp_valid_q, rsp_valid_nxt;
  logic [1:0]        grant_c;
  logic              gnt_id_c;
  ram_cmd_t          cmd_c;

  rr_arb2 u_rr_arb2 (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (state == RUN),
    .valid   (bus.req_valid),
    .grant_c (grant_c)
  );

  // Route the granted requester's command onto a common bus.
  always_comb begin : req_select
    cmd_c      = '0;
    gnt_id_c   = grant_c[1];
    cmd_c.we   = bus.req_we[gnt_id_c];
    cmd_c.addr = gnt_id_c ? RAM_ADDR_W'(bus.req_addr1) : RAM_ADDR_W'(bus.req_addr0);
    cmd_c.data = gnt_id_c ? bus.req_wdata1 : bus.req_wdata0;
  end

  always_ff @(posedge clk or negedge rst_n) begin : state_reg
    if (!rst_n) begin
      state       <= INIT;
      sweep_addr  <= '0;
      init_done_q <= 1'b0;
      rsp_valid_q <= 2'b00;
    end else begin
      state       <= state_nxt;
      sweep_addr  <= sweep_nxt;
      init_done_q <= init_done_nxt;
      rsp_valid_q <= rsp_valid_nxt;
    end
  end

  // INIT clears one word per cycle; RUN forwards at most one granted request.
  always_comb begin : fsm_next
    state_nxt      = state;
    sweep_nxt      = sweep_addr;
    init_done_nxt  = init_done_q;
    rsp_valid_nxt  = 2'b00;
    ram_write_en   = 1'b0;
    ram_write_addr = '0;
    ram_write_data = '0;
    ram_read_en    = 1'b0;
    ram_read_addr  = '0;
    case (state)
      INIT: begin
        ram_write_en   = 1'b1;
        ram_write_addr = RAM_ADDR_W'(sweep_addr);
        if (sweep_addr == LAST_ADDR) begin
          state_nxt     = RUN;
          init_done_nxt = 1'b1;
        end else begin
          sweep_nxt = sweep_addr + ADDR_W'(1);
        end
      end
      RUN: begin
        if (|grant_c) begin
          if (cmd_c.we) begin
            ram_write_en   = 1'b1;
            ram_write_addr = cmd_c.addr;
            ram_write_data = cmd_c.data;
          end else begin
            ram_read_en   = 1'b1;
            ram_read_addr = cmd_c.addr;
            rsp_valid_nxt = grant_c;
          end
        end
      end
      default: state_nxt = INIT;
    endcase
  end

  // RAM read data lands one cycle after the read, alongside the registered strobe.
  assign bus.req_ready = grant_c;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = (|rsp_valid_q) ? ram_read_data : '0;
  assign bus.init_done = init_done_q;

`ifdef RAM_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin : stats_reg
    if (!rst_n) begin
      grant_cnt0 <= '0;
      grant_cnt1 <= '0;
    end else begin
      if (grant_c[0] && (grant_cnt0 != '1)) grant_cnt0 <= grant_cnt0 + CNT_W'(1);
      if (grant_c[1] && (grant_cnt1 != '1)) grant_cnt1 <= grant_cnt1 + CNT_W'(1);
    end
  end
`else
  // No grant statistics in this build.
`endif

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Randomized self-checking bench for ram_port_arbiter against a behavioural arbitration/RAM model.
module tb_ram_port_arbiter;
  import ram_arb_pkg::*;

  localparam int unsigned T_DEPTH  = 8;
  localparam int unsigned T_ADDR_W = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ram_port_arbiter_if #(.ADDR_W(T_ADDR_W)) bus ();

  logic       ram_write_en, ram_read_en;
  logic [7:0] ram_write_addr, ram_read_addr;
  logic [3:0] ram_write_data;
  logic [3:0] ram_read_data = 4'h0;
  logic [3:0] ram_mem [256] = '{default: 4'h0};
`ifdef RAM_ARB_STATS_EN
  logic [7:0] grant_cnt0, grant_cnt1;
`endif

  ram_port_arbiter #(.DEPTH(T_DEPTH), .ADDR_W(T_ADDR_W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .bus            (bus),
    .ram_write_en   (ram_write_en),
    .ram_write_addr (ram_write_addr),
    .ram_write_data (ram_write_data),
    .ram_read_en    (ram_read_en),
    .ram_read_addr  (ram_read_addr),
    .ram_read_data  (ram_read_data)
`ifdef RAM_ARB_STATS_EN
    ,
    .grant_cnt0     (grant_cnt0),
    .grant_cnt1     (grant_cnt1)
`endif
  );

  // Registered-read RAM the arbiter drives.
  always @(posedge clk) begin
    if (ram_write_en) ram_mem[ram_write_addr] <= ram_write_data;
    if (ram_read_en)  ram_read_data <= ram_mem[ram_read_addr];
  end

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: favoured requester, word contents, response due next cycle.
  int         fav;
  int         winner;
  logic [3:0] model_mem [T_DEPTH];
  logic [1:0] exp_ready, exp_rsp_valid, nxt_rsp_valid;
  logic [3:0] exp_rsp_data, nxt_rsp_data, exp_wdata;
  logic       exp_wen, exp_ren;
  logic [7:0] exp_waddr, exp_raddr;

  task automatic model_reset();
    fav = 0;
    for (int i = 0; i < int'(T_DEPTH); i++) model_mem[i] = 4'h0;
    exp_rsp_valid = 2'b00;
    exp_rsp_data  = 4'h0;
  endtask

  task automatic model_predict();
    logic [2:0] a;
    logic [3:0] d;
    winner = -1;
    if (bus.req_valid == 2'b11) winner = fav;
    else if (bus.req_valid[0]) winner = 0;
    else if (bus.req_valid[1]) winner = 1;
    exp_ready = 2'b00; exp_wen = 1'b0; exp_ren = 1'b0;
    exp_waddr = 8'h00; exp_raddr = 8'h00; exp_wdata = 4'h0;
    nxt_rsp_valid = 2'b00; nxt_rsp_data = 4'h0;
    if (winner >= 0) begin
      exp_ready[winner] = 1'b1;
      a = (winner == 0) ? bus.req_addr0 : bus.req_addr1;
      d = (winner == 0) ? bus.req_wdata0 : bus.req_wdata1;
      if (bus.req_we[winner]) begin
        exp_wen = 1'b1; exp_waddr = {5'b0, a}; exp_wdata = d;
      end else begin
        exp_ren = 1'b1; exp_raddr = {5'b0, a};
        nxt_rsp_valid[winner] = 1'b1;
        nxt_rsp_data = model_mem[a];
      end
    end
  endtask

  task automatic model_commit();
    if (winner >= 0) begin
      if (bus.req_valid == 2'b11) fav = 1 - winner;
      if (exp_wen) model_mem[exp_waddr[2:0]] = exp_wdata;
    end
    exp_rsp_valid = nxt_rsp_valid;
    exp_rsp_data  = nxt_rsp_data;
  endtask

  task automatic drive(input logic [1:0] v, input logic [1:0] we,
                       input logic [2:0] a0, input logic [2:0] a1,
                       input logic [3:0] d0, input logic [3:0] d1);
    bus.req_valid  = v;
    bus.req_we     = we;
    bus.req_addr0  = a0;
    bus.req_addr1  = a1;
    bus.req_wdata0 = d0;
    bus.req_wdata1 = d1;
  endtask

  task automatic reset_dut();
    bit done = 0;
    rst_n = 1'b0;
    drive(2'b00, 2'b00, 3'd0, 3'd0, 4'h0, 4'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      done = bus.init_done;
    end
    n_cmp++;
    if (!done) begin
      n_err++;
      $display("FAIL init_timeout: init_done=%b want 1 within 20 cycles", bus.init_done);
    end
    model_reset();
  endtask

  task automatic test_reset();
    drive(2'b11, 2'b00, 3'd1, 3'd2, 4'h0, 4'h0);
    @(negedge clk); #1;
    n_cmp++; if (bus.req_ready !== 2'b00) begin n_err++; $display("FAIL rst_ready: got %b want 00", bus.req_ready); end
    n_cmp++; if (bus.rsp_valid !== 2'b00) begin n_err++; $display("FAIL rst_rsp_valid: got %b want 00", bus.rsp_valid); end
    n_cmp++; if (bus.rsp_data !== 4'h0) begin n_err++; $display("FAIL rst_rsp_data: got %h want 0", bus.rsp_data); end
    n_cmp++; if (bus.init_done !== 1'b0) begin n_err++; $display("FAIL rst_init_done: got %b want 0", bus.init_done); end
    n_cmp++; if (ram_read_en !== 1'b0) begin n_err++; $display("FAIL rst_read_en: got %b want 0", ram_read_en); end
  endtask

  task automatic test_init_sweep();
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      #1;
      n_cmp++;
      if (ram_write_en !== 1'b1 || ram_write_addr !== 8'(k) || ram_write_data !== 4'h0 || ram_read_en !== 1'b0)
        begin n_err++; $display("FAIL sweep_wr[%0d]: got en=%b addr=%h data=%h ren=%b want en=1 addr=%h data=0 ren=0",
                                k, ram_write_en, ram_write_addr, ram_write_data, ram_read_en, 8'(k)); end
      n_cmp++;
      if (bus.req_ready !== 2'b00 || bus.init_done !== 1'b0)
        begin n_err++; $display("FAIL sweep_ready[%0d]: got ready=%b init_done=%b want 00/0", k, bus.req_ready, bus.init_done); end
      @(negedge clk);
    end
    #1;
    n_cmp++; if (bus.init_done !== 1'b1) begin n_err++; $display("FAIL sweep_done: got %b want 1", bus.init_done); end
    drive(2'b00, 2'b00, 3'd0, 3'd0, 4'h0, 4'h0);
  endtask

  task automatic test_write_read();
    reset_dut();
    drive(2'b01, 2'b01, 3'd5, 3'd0, 4'hA, 4'h0); #1; model_predict();
    n_cmp++;
    if (bus.req_ready !== 2'b01 || ram_write_en !== 1'b1 || ram_write_addr !== 8'h05 || ram_write_data !== 4'hA || ram_read_en !== 1'b0)
      begin n_err++; $display("FAIL wr_a5: got ready=%b wen=%b addr=%h data=%h ren=%b want 01/1/05/a/0",
                              bus.req_ready, ram_write_en, ram_write_addr, ram_write_data, ram_read_en); end
    model_commit(); @(negedge clk);
    drive(2'b10, 2'b00, 3'd0, 3'd5, 4'h0, 4'h0); #1; model_predict();
    n_cmp++;
    if (bus.req_ready !== 2'b10 || ram_read_en !== 1'b1 || ram_read_addr !== 8'h05 || ram_write_en !== 1'b0 || bus.rsp_valid !== 2'b00)
      begin n_err++; $display("FAIL rd_a5: got ready=%b ren=%b addr=%h wen=%b rsp=%b want 10/1/05/0/00",
                              bus.req_ready, ram_read_en, ram_read_addr, ram_write_en, bus.rsp_valid); end
    model_commit(); @(negedge clk);
    drive(2'b00, 2'b00, 3'd0, 3'd0, 4'h0, 4'h0); #1; model_predict();
    n_cmp++;
    if (bus.rsp_valid !== 2'b10 || bus.rsp_data !== 4'hA)
      begin n_err++; $display("FAIL rsp_a5: got valid=%b data=%h want 10/a", bus.rsp_valid, bus.rsp_data); end
    n_cmp++;
    if (ram_write_en !== 1'b0 || ram_read_en !== 1'b0 || ram_write_addr !== 8'h00 || ram_write_data !== 4'h0 || ram_read_addr !== 8'h00)
      begin n_err++; $display("FAIL idle_port: got wen=%b ren=%b waddr=%h wdata=%h raddr=%h want all 0",
                              ram_write_en, ram_read_en, ram_write_addr, ram_write_data, ram_read_addr); end
    model_commit(); @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [1:0] want [4];
    logic [1:0] prev = 2'b00;
    want[0] = 2'b01; want[1] = 2'b10; want[2] = 2'b01; want[3] = 2'b10;
    reset_dut();
    for (int c = 0; c < 5; c++) begin
      if (c < 4) drive(2'b11, 2'b00, 3'd1, 3'd2, 4'h0, 4'h0);
      else       drive(2'b00, 2'b00, 3'd0, 3'd0, 4'h0, 4'h0);
      #1; model_predict();
      if (c < 4) begin
        n_cmp++;
        if (bus.req_ready !== want[c]) begin n_err++; $display("FAIL alt_grant[%0d]: got %b want %b", c, bus.req_ready, want[c]); end
      end
      n_cmp++;
      if (bus.rsp_valid !== prev) begin n_err++; $display("FAIL b2b_rsp[%0d]: got %b want %b", c, bus.rsp_valid, prev); end
      prev = (c < 4) ? want[c] : 2'b00;
      model_commit(); @(negedge clk);
    end
  endtask

  task automatic test_ptr_hold();
    reset_dut();
    for (int c = 0; c < 4; c++) begin
      drive((c < 3) ? 2'b10 : 2'b11, 2'b11, 3'd3, 3'd4, 4'h1, 4'h2);
      #1; model_predict();
      n_cmp++;
      if (bus.req_ready !== ((c < 3) ? 2'b10 : 2'b01))
        begin n_err++; $display("FAIL ptr_hold[%0d]: got %b want %b", c, bus.req_ready, (c < 3) ? 2'b10 : 2'b01); end
      model_commit(); @(negedge clk);
    end
    drive(2'b00, 2'b00, 3'd0, 3'd0, 4'h0, 4'h0);
  endtask

  task automatic test_reset_mid_sweep();
    reset_dut();
    drive(2'b01, 2'b00, 3'd2, 3'd0, 4'h0, 4'h0); #1; model_predict(); model_commit();
    @(posedge clk); #1;
    drive(2'b00, 2'b00, 3'd0, 3'd0, 4'h0, 4'h0);
    n_cmp++; if (bus.rsp_valid !== 2'b01) begin n_err++; $display("FAIL pend_rsp: got %b want 01", bus.rsp_valid); end
    rst_n = 1'b0; #1;
    n_cmp++;
    if (bus.rsp_valid !== 2'b00 || bus.rsp_data !== 4'h0)
      begin n_err++; $display("FAIL rsp_killed: got valid=%b data=%h want 00/0", bus.rsp_valid, bus.rsp_data); end
    @(negedge clk); rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin #1; @(negedge clk); end
    #1;
    n_cmp++; if (ram_write_addr !== 8'h04) begin n_err++; $display("FAIL sweep_at4: got %h want 04", ram_write_addr); end
    rst_n = 1'b0; #1; rst_n = 1'b1; #1;
    n_cmp++;
    if (ram_write_en !== 1'b1 || ram_write_addr !== 8'h00)
      begin n_err++; $display("FAIL sweep_restart: got en=%b addr=%h want 1/00", ram_write_en, ram_write_addr); end
    @(negedge clk);
    for (int k = 1; k < 8; k++) begin
      #1;
      n_cmp++;
      if (ram_write_addr !== 8'(k) || bus.init_done !== 1'b0)
        begin n_err++; $display("FAIL resweep[%0d]: got addr=%h done=%b want %h/0", k, ram_write_addr, bus.init_done, 8'(k)); end
      @(negedge clk);
    end
    #1;
    n_cmp++; if (bus.init_done !== 1'b1) begin n_err++; $display("FAIL resweep_done: got %b want 1", bus.init_done); end
  endtask

  task automatic test_random();
    reset_dut();
    for (int i = 0; i < 300; i++) begin
      drive(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
            3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      #1; model_predict();
      n_cmp++;
      if (bus.req_ready !== exp_ready) begin n_err++; $display("FAIL rnd_ready[%0d]: got %b want %b", i, bus.req_ready, exp_ready); end
      n_cmp++;
      if (ram_write_en !== exp_wen || ram_write_addr !== exp_waddr || ram_write_data !== exp_wdata)
        begin n_err++; $display("FAIL rnd_wr[%0d]: got %b/%h/%h want %b/%h/%h", i, ram_write_en, ram_write_addr,
                                ram_write_data, exp_wen, exp_waddr, exp_wdata); end
      n_cmp++;
      if (ram_read_en !== exp_ren || ram_read_addr !== exp_raddr)
        begin n_err++; $display("FAIL rnd_rd[%0d]: got %b/%h want %b/%h", i, ram_read_en, ram_read_addr, exp_ren, exp_raddr); end
      n_cmp++;
      if (bus.rsp_valid !== exp_rsp_valid) begin n_err++; $display("FAIL rnd_rsp_valid[%0d]: got %b want %b", i, bus.rsp_valid, exp_rsp_valid); end
      if (exp_rsp_valid != 2'b00) begin
        n_cmp++;
        if (bus.rsp_data !== exp_rsp_data) begin n_err++; $display("FAIL rnd_rsp_data[%0d]: got %h want %h", i, bus.rsp_data, exp_rsp_data); end
      end
      model_commit(); @(negedge clk);
    end
    drive(2'b00, 2'b00, 3'd0, 3'd0, 4'h0, 4'h0);
  endtask

`ifdef RAM_ARB_STATS_EN
  task automatic test_stats();
    reset_dut();
    n_cmp++; if (grant_cnt0 !== 8'd0) begin n_err++; $display("FAIL cnt0_rst: got %0d want 0", grant_cnt0); end
    for (int i = 0; i < 300; i++) begin
      drive(2'b01, 2'b01, 3'($urandom_range(0, 7)), 3'd0, 4'($urandom_range(0, 15)), 4'h0);
      #1; model_predict(); model_commit(); @(negedge clk);
      if (i == 99) begin
        n_cmp++; if (grant_cnt0 !== 8'd100) begin n_err++; $display("FAIL cnt0_100: got %0d want 100", grant_cnt0); end
      end
    end
    drive(2'b00, 2'b00, 3'd0, 3'd0, 4'h0, 4'h0);
    n_cmp++; if (grant_cnt0 !== 8'd255) begin n_err++; $display("FAIL cnt0_sat: got %0d want 255", grant_cnt0); end
    n_cmp++; if (grant_cnt1 !== 8'd0) begin n_err++; $display("FAIL cnt1_idle: got %0d want 0", grant_cnt1); end
  endtask
`endif

  initial begin
    model_reset();
    test_reset();
    test_init_sweep();
    test_write_read();
    test_back_to_back();
    test_ptr_hold();
    test_reset_mid_sweep();
    test_random();
`ifdef RAM_ARB_STATS_EN
    test_stats();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ram_port_arbiter.md
RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

Interface
REQ-001 Parameter: DEPTH, default 8, number of RAM words; init sweep covers addresses 0..DEPTH-1.
REQ-002 Parameter: ADDR_W, default 3, requester address width; SHALL equal clog2(DEPTH).
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 req_valid[1:0]  input  2  per-requester request valid.
REQ-006 req_we[1:0]  input  2  per-requester op: 1 = write, 0 = read.
REQ-007 req_addr0, req_addr1  input  ADDR_W each  word address.
REQ-008 req_wdata0, req_wdata1  input  4 each  write data.
REQ-009 req_ready[1:0]  output  2  per-requester grant; transfer occurs when valid and ready are both high.
REQ-010 rsp_valid[1:0]  output  2  read-response strobe, one per accepted read.
REQ-011 rsp_data  output  4  read data, qualified by rsp_valid.
REQ-012 init_done  output  1  high once the post-reset clear sweep completes.
REQ-013 ram_write_en, ram_write_addr[7:0], ram_write_data[3:0]  output  RAM write port.
REQ-014 ram_read_en, ram_read_addr[7:0]  output  RAM read port; ram_read_data[3:0]  input  registered RAM read data, 1-cycle latency.

Function
REQ-015 FSM states SHALL be INIT and RUN; reset enters INIT.
REQ-016 INIT SHALL write 0 to addresses 0..DEPTH-1, one per cycle, ascending, then enter RUN and set init_done; req_ready SHALL be 0 throughout INIT.
REQ-017 In RUN, at most one request SHALL be granted per cycle; req_ready SHALL be combinational from req_valid and the rr pointer.
REQ-018 Only one valid -> that requester granted; both valid -> requester named by rr pointer granted.
REQ-019 rr pointer SHALL update only on a contended grant, to the non-granted requester; uncontended grants leave it unchanged.
REQ-020 Granted write -> ram_write_en=1 in the same cycle, with address zero-extended to 8 bits and data passed through; no response.
REQ-021 Granted read -> ram_read_en=1 in the same cycle; next cycle rsp_valid[id]=1 and rsp_data=ram_read_data.
REQ-022 ram_write_en and ram_read_en SHALL never both be 1 in one cycle.
REQ-023 Back-to-back reads SHALL produce back-to-back responses, each tagged with its own requester id.
REQ-024 When idle, ram_*_en SHALL be 0; address and data outputs SHALL be 0.

Reset
REQ-025 Reset values: state INIT, sweep address 0, rr pointer 0 (requester 0 favoured), rsp_valid 0, rsp_data 0, init_done 0.
REQ-026 Reset asserted mid-sweep or mid-read SHALL discard the pending response and restart the sweep at address 0.

Configuration
REQ-027 Macro RAM_ARB_STATS_EN defined: add outputs grant_cnt0 and grant_cnt1, 8 bits each; each SHALL increment on every accepted transfer of its requester, saturate at 255, and reset to 0.
REQ-028 RAM_ARB_STATS_EN undefined: grant_cnt0 and grant_cnt1 and their logic SHALL be absent; all other behaviour is identical.

Structure
REQ-029 Shared package ram_arb_pkg SHALL hold the FSM state enum, the DEPTH and ADDR_W defaults, and the RAM address width constant of 8.
REQ-030 Sub-module rr_arb2 (2-way round-robin grant plus pointer register) SHALL be instantiated once.

Verification
REQ-031 Reset release, requests held -> ram_write_en high 8 cycles, addresses 0..7, data 0; init_done rises on cycle 9; no req_ready before that.
REQ-032 Req0 write addr 5 data 0xA, then req1 read addr 5 -> next cycle rsp_valid=2'b10, rsp_data=0xA.
REQ-033 Both requesters valid for 4 cycles after reset -> grants alternate 0,1,0,1.
REQ-034 Req1 alone valid 3 cycles, then both valid -> req1 granted 3 times, then req0 granted (pointer unchanged).
REQ-035 rst_n pulsed low during sweep address 4 -> sweep restarts at 0; pending rsp_valid cleared.
REQ-036 With RAM_ARB_STATS_EN, 300 req0 grants -> grant_cnt0 = 255.
